// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry and the
// feeder state encoding.
package uart_pkg;

    localparam int UART_FRAME_WIDTH  = 32;
    localparam int UART_FRAME_CYCLES = 36;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_DONE = 2'b10
    } feed_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered read port; the popped word appears on
// rd_data after the popping edge and holds until the next pop.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_FRAME_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     push,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign count     = wr_ptr_q - rd_ptr_q;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = rd_data_q;

    // Pointer and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_INC;
            end
            if (do_pop_s) begin
                rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
                rd_ptr_q  <= rd_ptr_q + PTR_INC;
            end
        end
    end

    // Storage array; contents are don't-care once pointers are reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host words and hands them one at a time to the UART transmitter,
// counting completed frames and flagging stalled frames with a watchdog.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int WIDTH   = UART_FRAME_WIDTH,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 256
) (
    input  logic                   CLK_Baudin,
    input  logic                   RstTx,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    output logic [WIDTH-1:0]       DataOut,
    output logic                   NewData,
    input  logic                   DoneTx,
    input  logic                   clr_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            frames_sent,
    output logic                   timeout_err
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_ONE  = {{(WDW-1){1'b0}}, 1'b1};
    localparam logic [WDW-1:0] WDOG_MAX  = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WDOG_LAST = WDOG_MAX - WDOG_ONE;

    feed_state_e     state_q, state_d;
    logic            new_data_q, new_data_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [15:0]     frames_q, frames_d;
    logic            err_q, err_d;
    logic            pop_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;

    uart_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK_Baudin),
        .rst     (RstTx),
        .wr_data (wr_data),
        .push    (wr_valid),
        .pop     (pop_s),
        .rd_data (DataOut),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count)
    );

    assign wr_ready    = !fifo_full_s;
    assign NewData     = new_data_q;
    assign busy        = (state_q != IDLE);
    assign frames_sent = frames_q;
    assign timeout_err = err_q;

    // Feeder state, watchdog and counter registers.
    always_ff @(posedge CLK_Baudin or posedge RstTx) begin
        if (RstTx) begin
            state_q    <= IDLE;
            new_data_q <= 1'b0;
            wdog_q     <= '0;
            frames_q   <= 16'h0000;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            new_data_q <= new_data_d;
            wdog_q     <= wdog_d;
            frames_q   <= frames_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic; a timeout raised in the same cycle as clr_err wins.
    always_comb begin
        state_d    = state_q;
        new_data_d = 1'b0;
        wdog_d     = wdog_q;
        frames_d   = frames_q;
        err_d      = err_q & ~clr_err;
        pop_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    new_data_d = 1'b1;
                    state_d    = ISSUE;
                end else begin
                    state_d    = IDLE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (wdog_q != WDOG_MAX) begin
                    wdog_d = wdog_q + WDOG_ONE;
                end else begin
                    wdog_d = wdog_q;
                end
                if (DoneTx) begin
                    frames_d = frames_q + 16'h0001;
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        new_data_d = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        state_d    = IDLE;
                    end
                end else if (wdog_q == WDOG_LAST) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q & ~clr_err;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter model that
// raises DoneTx a fixed number of edges after sampling NewData.
module tb_uart_tx_feeder;

    logic        CLK_Baudin = 1'b0;
    logic        RstTx;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] DataOut;
    logic        NewData;
    logic        DoneTx;
    logic        clr_err;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [15:0] frames_sent;
    logic        timeout_err;

    logic        tx_stall;
    int          tx_cnt;
    int          checks = 0;
    int          errors = 0;
    int          n;
    logic        prev_done;

    uart_tx_feeder #(
        .WIDTH   (32),
        .DEPTH   (8),
        .TIMEOUT (256)
    ) dut (
        .CLK_Baudin  (CLK_Baudin),
        .RstTx       (RstTx),
        .wr_data     (wr_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .DataOut     (DataOut),
        .NewData     (NewData),
        .DoneTx      (DoneTx),
        .clr_err     (clr_err),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .frames_sent (frames_sent),
        .timeout_err (timeout_err)
    );

    always #5 CLK_Baudin = ~CLK_Baudin;

    // Transmitter model; tx_stall emulates retransmissions holding DoneTx low.
    always_ff @(posedge CLK_Baudin or posedge RstTx) begin
        if (RstTx) begin
            tx_cnt <= 0;
            DoneTx <= 1'b0;
        end else if (NewData) begin
            tx_cnt <= uart_pkg::UART_FRAME_CYCLES;
            DoneTx <= 1'b0;
        end else if (tx_cnt != 0 && !tx_stall) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) DoneTx <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RstTx = 1'b1; wr_data = 32'h0; wr_valid = 1'b0; clr_err = 1'b0; tx_stall = 1'b0;
        #3;
        check("rst_dataout",  DataOut, 32'h0);
        check("rst_newdata",  32'(NewData), 32'h0);
        check("rst_wr_ready", 32'(wr_ready), 32'h1);
        check("rst_busy",     32'(busy), 32'h0);
        check("rst_count",    32'(fifo_count), 32'h0);
        check("rst_frames",   32'(frames_sent), 32'h0);
        check("rst_timeout",  32'(timeout_err), 32'h0);
        @(negedge CLK_Baudin);
        @(negedge CLK_Baudin);
        RstTx = 1'b0;

        // Single word
        @(negedge CLK_Baudin); wr_data = 32'hA5A5_0F0F; wr_valid = 1'b1;
        @(negedge CLK_Baudin); wr_valid = 1'b0;
        check("single_count1", 32'(fifo_count), 32'h1);
        check("single_nd_early", 32'(NewData), 32'h0);
        @(negedge CLK_Baudin);
        check("single_nd", 32'(NewData), 32'h1);
        check("single_data", DataOut, 32'hA5A5_0F0F);
        check("single_busy", 32'(busy), 32'h1);
        check("single_count0", 32'(fifo_count), 32'h0);
        @(negedge CLK_Baudin);
        check("single_nd_pulse", 32'(NewData), 32'h0);
        check("single_data_hold", DataOut, 32'hA5A5_0F0F);
        n = 0;
        while (frames_sent != 16'd1 && n < 200) begin @(negedge CLK_Baudin); n++; end
        check("single_latency", 32'(n), 32'd37);
        check("single_frames", 32'(frames_sent), 32'h1);
        check("single_idle", 32'(busy), 32'h0);

        // Fill with DoneTx held low
        tx_stall = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge CLK_Baudin); wr_data = 32'h0000_0100 + 32'(k); wr_valid = 1'b1;
        end
        @(negedge CLK_Baudin); wr_data = 32'h0000_0109;
        check("fill_count", 32'(fifo_count), 32'h8);
        check("fill_ready", 32'(wr_ready), 32'h0);
        check("fill_head", DataOut, 32'h0000_0100);
        @(negedge CLK_Baudin);
        @(negedge CLK_Baudin);
        check("fill_stall_count", 32'(fifo_count), 32'h8);
        check("fill_stall_ready", 32'(wr_ready), 32'h0);
        tx_stall = 1'b0;
        n = 0;
        while (wr_ready !== 1'b1 && n < 100) begin @(negedge CLK_Baudin); n++; end
        check("fill_release_nd", 32'(NewData), 32'h1);
        check("fill_release_data", DataOut, 32'h0000_0101);
        check("fill_release_count", 32'(fifo_count), 32'h7);
        check("fill_release_frames", 32'(frames_sent), 32'h2);
        @(negedge CLK_Baudin); wr_valid = 1'b0;
        check("fill_tenth", 32'(fifo_count), 32'h8);
        n = 0;
        while ((busy || fifo_count != 4'd0) && n < 1000) begin @(negedge CLK_Baudin); n++; end
        check("drain_idle", 32'(busy), 32'h0);
        check("drain_frames", 32'(frames_sent), 32'd11);
        check("drain_timeout", 32'(timeout_err), 32'h0);

        // Back-to-back frames
        @(negedge CLK_Baudin); wr_data = 32'h1; wr_valid = 1'b1;
        @(negedge CLK_Baudin); wr_data = 32'h2;
        @(negedge CLK_Baudin);
        check("b2b_nd1", 32'(NewData), 32'h1);
        check("b2b_data1", DataOut, 32'h1);
        wr_data = 32'h3;
        n = 0;
        for (int w = 2; w <= 3; w++) begin
            do begin
                prev_done = DoneTx;
                @(negedge CLK_Baudin);
                wr_valid = 1'b0;
                n++;
            end while (NewData !== 1'b1 && n < 200);
            check("b2b_gap", 32'(n), 32'd38);
            check("b2b_data", DataOut, 32'(w));
            check("b2b_done_seen", 32'(prev_done), 32'h1);
            @(negedge CLK_Baudin);
            check("b2b_pulse", 32'(NewData), 32'h0);
            n = 1;
        end
        n = 0;
        while (busy && n < 200) begin @(negedge CLK_Baudin); n++; end
        check("b2b_frames", 32'(frames_sent), 32'd14);

        // Watchdog
        tx_stall = 1'b1;
        @(negedge CLK_Baudin); wr_data = 32'hDEAD_BEEF; wr_valid = 1'b1;
        @(negedge CLK_Baudin); wr_valid = 1'b0;
        @(negedge CLK_Baudin);
        check("wd_nd", 32'(NewData), 32'h1);
        @(negedge CLK_Baudin);
        repeat (255) @(negedge CLK_Baudin);
        check("wd_before", 32'(timeout_err), 32'h0);
        clr_err = 1'b1;
        @(negedge CLK_Baudin);
        check("wd_set_wins", 32'(timeout_err), 32'h1);
        @(negedge CLK_Baudin);
        check("wd_cleared", 32'(timeout_err), 32'h0);
        clr_err = 1'b0;
        repeat (5) @(negedge CLK_Baudin);
        check("wd_stays_clear", 32'(timeout_err), 32'h0);
        check("wd_still_busy", 32'(busy), 32'h1);
        check("wd_data_kept", DataOut, 32'hDEAD_BEEF);
        tx_stall = 1'b0;
        n = 0;
        while (busy && n < 200) begin @(negedge CLK_Baudin); n++; end
        check("wd_complete", 32'(busy), 32'h0);
        check("wd_frames", 32'(frames_sent), 32'd15);

        // Reset mid-frame
        tx_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK_Baudin); wr_data = 32'h0000_0200 + 32'(k); wr_valid = 1'b1;
        end
        @(negedge CLK_Baudin); wr_valid = 1'b0;
        check("mid_count", 32'(fifo_count), 32'h3);
        check("mid_busy", 32'(busy), 32'h1);
        check("mid_head", DataOut, 32'h0000_0200);
        #2 RstTx = 1'b1;
        #1;
        check("mid_rst_count", 32'(fifo_count), 32'h0);
        check("mid_rst_nd", 32'(NewData), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_data", DataOut, 32'h0);
        check("mid_rst_frames", 32'(frames_sent), 32'h0);
        check("mid_rst_ready", 32'(wr_ready), 32'h1);
        @(negedge CLK_Baudin); RstTx = 1'b0; tx_stall = 1'b0;
        @(negedge CLK_Baudin); wr_data = 32'h1234_5678; wr_valid = 1'b1;
        @(negedge CLK_Baudin); wr_valid = 1'b0;
        @(negedge CLK_Baudin);
        check("post_nd", 32'(NewData), 32'h1);
        check("post_data", DataOut, 32'h1234_5678);
        n = 0;
        while (busy && n < 200) begin @(negedge CLK_Baudin); n++; end
        check("post_frames", 32'(frames_sent), 32'h1);
        check("post_idle", 32'(busy), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
